// File: rtl/sram_ctrl_burst_pkg.sv
// Shared types and helpers for the burst SRAM controller: FSM encoding,
// beat-count sizing and processor-to-SRAM address mapping.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max_beats(input int wr_beats, input int rd_beats);
    return (wr_beats > rd_beats) ? wr_beats : rd_beats;
  endfunction

  // Beat counter width; a single-beat configuration still needs one bit.
  function automatic int beat_cnt_w(input int beats);
    return (clog2(beats) < 1) ? 1 : clog2(beats);
  endfunction

  // Word address of one beat: byte address scaled to SRAM words, with the
  // low beat_bits replaced by the beat index so bursts stay naturally aligned.
  function automatic logic [63:0] map_addr(input logic [63:0] mem_addr,
                                           input int byte_shift,
                                           input int beat_bits,
                                           input logic [63:0] beat);
    logic [63:0] mask;
    mask = (64'd1 << beat_bits) - 64'd1;
    return ((mem_addr >> byte_shift) & ~mask) | (beat & mask);
  endfunction

endpackage

// File: rtl/sram_ctrl_burst_if.sv
// Processor-side request/response bundle of the burst SRAM controller.
interface sram_ctrl_burst_if #(
  parameter int ADDR_W = 32,
  parameter int WR_W   = 32,
  parameter int RD_W   = 64
);
  // write_en/read_en act as valid: held high until ready is seen high while the
  // request is still asserted, then dropped the next cycle. ready is also high
  // in idle when nothing is requested; operands are latched on acceptance.
  logic              write_en;
  logic              read_en;
  logic [ADDR_W-1:0] address;
  logic [WR_W-1:0]   write_data;
  logic [RD_W-1:0]   read_data;
  logic              ready;

  modport master (output write_en, read_en, address, write_data,
                  input  read_data, ready);
  modport slave  (input  write_en, read_en, address, write_data,
                  output read_data, ready);
endinterface

// File: rtl/sram_ctrl_burst_beat_timer.sv
// Wait-state and beat counters: wcnt walks 0..WAIT_CYCLES within a beat,
// beat advances at each beat end while run is high.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_BEATS   = 4,
  localparam int BW = beat_cnt_w(MAX_BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          run,
  input  logic [BW-1:0] last_idx,
  output logic [3:0]    wcnt,
  output logic [BW-1:0] beat,
  output logic          end_beat,
  output logic          last_beat
);

  assign end_beat  = run && (wcnt == 4'(WAIT_CYCLES));
  assign last_beat = end_beat && (beat == last_idx);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wcnt <= '0;
      beat <= '0;
    end else if (run) begin
      if (end_beat) begin
        wcnt <= '0;
        beat <= beat + 1'b1;
      end else begin
        wcnt <= wcnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sram_ctrl_burst.sv
// Burst controller for an asynchronous narrow SRAM: splits a wide write into
// WR_BEATS bus writes and gathers RD_BEATS bus reads into one read line.
module sram_ctrl_burst
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int DQ_W        = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WR_BEATS    = 2,
  parameter int RD_BEATS    = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_ctrl_burst_if.slave       bus,
  inout  wire  [DQ_W-1:0]        SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output state_t                 dbg_state
);

  localparam int WR_W       = WR_BEATS * DQ_W;
  localparam int RD_W       = RD_BEATS * DQ_W;
  localparam int BYTE_SHIFT = clog2(DQ_W / 8);
  localparam int WR_BITS    = clog2(WR_BEATS);
  localparam int RD_BITS    = clog2(RD_BEATS);
  localparam int MAXB       = max_beats(WR_BEATS, RD_BEATS);
  localparam int BW         = beat_cnt_w(MAXB);

  state_t            state, next_state;
  logic              op_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [WR_W-1:0]   wdata;
  logic [RD_W-1:0]   rd_buf, rd_next, read_data_q;
  logic [3:0]        wcnt;
  logic [BW-1:0]     beat;
  logic              end_beat, last_beat;
  logic              accept, dq_oe, ready_c;

  assign accept = bus.write_en | bus.read_en;

  sram_beat_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .MAX_BEATS   (MAXB)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != ACCESS),
    .run       (state == ACCESS),
    .last_idx  (op_write ? BW'(WR_BEATS - 1) : BW'(RD_BEATS - 1)),
    .wcnt      (wcnt),
    .beat      (beat),
    .end_beat  (end_beat),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ACCESS;
      ACCESS:  if (last_beat) next_state = TURN;
      TURN:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    ready_c   = 1'b0;
    case (state)
      IDLE:   ready_c = !accept;
      ACCESS: begin
        SRAM_CE_N = 1'b0;
        if (op_write) begin
          dq_oe     = 1'b1;
          // WE_N stays high on the first cycle of each beat for address setup.
          SRAM_WE_N = (wcnt == 4'd0);
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      TURN:   ready_c = 1'b0;
      DONE:   ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  // Operands are captured on acceptance so the master may move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_write <= 1'b0;
      mem_addr <= '0;
      wdata    <= '0;
    end else if (state == IDLE && accept) begin
      op_write <= bus.write_en;
      mem_addr <= bus.address - ADDR_W'(BASE_ADDR);
      wdata    <= bus.write_data;
    end
  end

  always_comb begin
    rd_next = rd_buf;
    rd_next[beat*DQ_W +: DQ_W] = SRAM_DQ;
  end

  // Beats gather in rd_buf; the visible line only changes when a read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_buf      <= '0;
      read_data_q <= '0;
    end else if (state == ACCESS && !op_write && end_beat) begin
      rd_buf <= rd_next;
      if (last_beat) read_data_q <= rd_next;
    end
  end

  assign SRAM_ADDR = SRAM_ADDR_W'(map_addr(64'(mem_addr), BYTE_SHIFT,
                                           op_write ? WR_BITS : RD_BITS,
                                           64'(beat)));
  assign SRAM_DQ       = dq_oe ? wdata[beat*DQ_W +: DQ_W] : 'z;
  assign SRAM_UB_N     = 1'b0;
  assign SRAM_LB_N     = 1'b0;
  assign bus.ready     = ready_c;
  assign bus.read_data = read_data_q;
  assign dbg_state     = state;

endmodule
